func_sweep_checker: RTL and testbench
=====================================

# func_sweep_checker

Sequential stimulus-and-capture engine for the 4-input logic function F = AC + ABC' + BD + A'C'D'. It drives all 16 input combinations onto an external function-under-test, waits a programmable settle time per vector, and samples the returned F. It then assembles the 16-bit truth table, compares it against the expected table, and reports pass/fail, mismatch count and the first failing vector. It sits on the reading side of the transistor-level function block: that block evaluates F, this block exercises it and reads it back.

## Interface
- SETTLE, 2: number of wait cycles per vector before sampling; 0 allowed, maximum 15.
- EXPECT, 16'hFCB1: expected truth table, bit i = F for {A,B,C,D} = i, with A as MSB.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- abcd_o  output  4  stimulus {A,B,C,D} to the function-under-test.
- f_i  input  1  F returned by the function-under-test; synchronous to clk within SETTLE+1 cycles, no synchronizer.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle completion pulse.
- table_o  output  16  captured truth table.
- pass  output  1  table_o == EXPECT; valid from done until the next accepted start.
- mismatch_cnt  output  5  number of differing bits, 0..16.
- err_idx  output  4  lowest mismatching index; 0 when pass = 1.

## Operation
- Reset (asynchronous, any state): state = IDLE. abcd_o, busy, done, table_o, pass, mismatch_cnt and err_idx all go to 0.
- **IDLE**
  - abcd_o = 0, busy = 0, done = 0.
  - Results hold their last values.
  - start = 1 at an edge: clear table_o, pass, mismatch_cnt and err_idx. Set idx = 0 and wait counter = 0. Go to DRIVE.
- **DRIVE**
  - busy = 1, abcd_o = idx.
  - Counter increments each cycle.
  - At the edge where counter == SETTLE:
    - table_o[idx] <= f_i.
    - If f_i != EXPECT[idx]: increment mismatch_cnt. If this is the first mismatch, err_idx <= idx.
    - If idx == 15, go to DONE. Otherwise idx++ and counter <= 0.
- **DONE**
  - One cycle: done = 1, busy = 0.
  - pass = (mismatch_cnt == 0), registered on entry.
  - abcd_o returns to 0.
  - Next edge goes to IDLE unconditionally.
- start is ignored in DRIVE and DONE. No queuing.
- Reset mid-sweep aborts the sweep. Partial results are discarded and all outputs take their reset values.
- Arithmetic:
  - idx is 4 bits and never wraps within a sweep; termination is on idx == 15.
  - mismatch_cnt is 5 bits so that 16 mismatches are representable.
  - Counter is 4 bits.

## Timing
- Each vector is held for exactly SETTLE+1 cycles. f_i is sampled at the last edge of that window.
- start seen high at edge k:
  - DRIVE starts at edge k.
  - DONE is entered at edge k + 16·(SETTLE+1).
  - done is high for the one cycle after that edge.
  - Default SETTLE = 2: done is high 48 cycles after start acceptance.
- table_o bit i updates at the sample edge of vector i. Bits are visible incrementally during the sweep.
- pass is valid from the DONE cycle onward. It is 0 throughout the sweep.
- start held high continuously gives back-to-back sweeps: DONE, then one IDLE cycle, then DRIVE.

## Test plan
- Correct gate model of F on f_i, SETTLE = 2, one start pulse:
  - done pulses exactly 48 cycles after acceptance.
  - table_o = 16'hFCB1, pass = 1, mismatch_cnt = 0, err_idx = 0.
  - abcd_o steps 0..15, each value held 3 cycles.
- f_i stuck at 0: table_o = 16'h0000, mismatch_cnt = 10, err_idx = 0, pass = 0.
- Single-vector fault, with f_i forced to 1 when abcd_o = 9: table_o = 16'hFEB1, mismatch_cnt = 1, err_idx = 9, pass = 0.
- Inverted F on f_i: table_o = 16'h034E, mismatch_cnt = 16, err_idx = 0.
- Reset and handshake:
  - rst_n low while abcd_o = 7: all outputs are 0 immediately.
  - After release, a new start produces a full correct sweep with pass = 1.
  - start pulses during busy are ignored, and done still arrives 48 cycles after the first accepted start.
- SETTLE = 0 with the correct model: 1 cycle per vector, done 16 cycles after acceptance, pass = 1.
- SETTLE = 0 with start held high: a second sweep begins one IDLE cycle after done.

Source files
------------

// File: rtl/func_sweep_checker.sv
// rtl/func_sweep_checker.sv - stimulus sweep and truth-table capture for F = AC + ABC' + BD + A'C'D'
module func_sweep_checker #(
    parameter int unsigned SETTLE = 2,
    parameter logic [15:0] EXPECT = 16'hFCB1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  abcd_o,
    input  logic        f_i,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_o,
    output logic        pass,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  err_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = SETTLE[3:0];

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] table_q, table_d;
    logic        pass_q, pass_d;
    logic [4:0]  mm_q, mm_d;
    logic [3:0]  err_q, err_d;

    // State and result registers; reset aborts any sweep and clears every result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            table_q <= 16'd0;
            pass_q  <= 1'b0;
            mm_q    <= 5'd0;
            err_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            pass_q  <= pass_d;
            mm_q    <= mm_d;
            err_q   <= err_d;
        end
    end

    // Next-state, sampling and mismatch bookkeeping; stimulus and status decode from state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        pass_d  = pass_q;
        mm_d    = mm_q;
        err_d   = err_q;
        abcd_o  = 4'd0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    table_d = 16'd0;
                    pass_d  = 1'b0;
                    mm_d    = 5'd0;
                    err_d   = 4'd0;
                    idx_d   = 4'd0;
                    cnt_d   = 4'd0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                busy   = 1'b1;
                abcd_o = idx_q;
                if (cnt_q == SETTLE_C) begin
                    // Last edge of the settle window: capture this vector's response.
                    table_d[idx_q] = f_i;
                    if (f_i != EXPECT[idx_q]) begin
                        mm_d = mm_q + 5'd1;
                        if (mm_q == 5'd0) begin
                            err_d = idx_q;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        // Pass is taken from the count including the final vector.
                        pass_d  = (mm_d == 5'd0);
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cnt_d = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign table_o      = table_q;
    assign pass         = pass_q;
    assign mismatch_cnt = mm_q;
    assign err_idx      = err_q;

endmodule

// File: tb/tb_func_sweep_checker.sv
// tb/tb_func_sweep_checker.sv - directed bench for func_sweep_checker
module tb_func_sweep_checker;

    logic        clk;
    logic        rst_n;
    logic        start2, start0;
    logic [3:0]  abcd2, abcd0;
    logic        f2, f0;
    logic        busy2, busy0, done2, done0, pass2, pass0;
    logic [15:0] table2, table0;
    logic [4:0]  mm2, mm0;
    logic [3:0]  err2, err0;

    int mode;
    logic sel;

    logic        busy_m, done_m, pass_m;
    logic [3:0]  abcd_m, err_m;
    logic [15:0] table_m;
    logic [4:0]  mm_m;

    int checks = 0;
    int failures = 0;

    func_sweep_checker #(.SETTLE(2), .EXPECT(16'hFCB1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abcd_o(abcd2), .f_i(f2),
        .busy(busy2), .done(done2), .table_o(table2), .pass(pass2),
        .mismatch_cnt(mm2), .err_idx(err2)
    );

    func_sweep_checker #(.SETTLE(0), .EXPECT(16'hFCB1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abcd_o(abcd0), .f_i(f0),
        .busy(busy0), .done(done0), .table_o(table0), .pass(pass0),
        .mismatch_cnt(mm0), .err_idx(err0)
    );

    function automatic logic f_gate(input logic [3:0] x);
        logic a, b, c, d;
        a = x[3]; b = x[2]; c = x[1]; d = x[0];
        return (a & c) | (a & b & ~c) | (b & d) | (~a & ~c & ~d);
    endfunction

    function automatic logic f_model(input int m, input logic [3:0] x);
        case (m)
            1:       return 1'b0;
            2:       return f_gate(x) | (x == 4'd9);
            3:       return ~f_gate(x);
            default: return f_gate(x);
        endcase
    endfunction

    assign f2 = f_model(mode, abcd2);
    assign f0 = f_model(mode, abcd0);

    assign busy_m  = sel ? busy0  : busy2;
    assign done_m  = sel ? done0  : done2;
    assign pass_m  = sel ? pass0  : pass2;
    assign abcd_m  = sel ? abcd0  : abcd2;
    assign err_m   = sel ? err0   : err2;
    assign table_m = sel ? table0 : table2;
    assign mm_m    = sel ? mm0    : mm2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_start(input logic v);
        if (sel) start0 = v;
        else     start2 = v;
    endtask

    // Accept one start, then watch every cycle until done; counts are relative to the accepting edge.
    task automatic run_sweep(input logic s, input int fmode, input int poke,
                             output int cycles, output int abcd_bad,
                             output int busy_bad, output int pass_bad);
        int per;
        int exp_a;
        sel  = s;
        mode = fmode;
        per  = s ? 1 : 3;
        cycles = 0; abcd_bad = 0; busy_bad = 0; pass_bad = 0;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        while (done_m !== 1'b1 && cycles < 200) begin
            exp_a = cycles / per;
            if (abcd_m !== exp_a[3:0]) abcd_bad++;
            if (busy_m !== 1'b1) busy_bad++;
            if (pass_m !== 1'b0) pass_bad++;
            @(negedge clk);
            cycles++;
            set_start((poke != 0) && (cycles % 10 == 5));
        end
        set_start(1'b0);
    endtask

    task automatic check_result(input string name, input int cycles, input int exp_cycles,
                                input logic [15:0] exp_tab, input logic [4:0] exp_mm,
                                input logic [3:0] exp_err, input logic exp_pass);
        checks++;
        if (cycles != exp_cycles) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, cycles, exp_cycles);
        end
        checks++;
        if (table_m !== exp_tab) begin
            failures++;
            $display("FAIL %s table: got %h want %h", name, table_m, exp_tab);
        end
        checks++;
        if (mm_m !== exp_mm) begin
            failures++;
            $display("FAIL %s mismatch_cnt: got %0d want %0d", name, mm_m, exp_mm);
        end
        checks++;
        if (err_m !== exp_err) begin
            failures++;
            $display("FAIL %s err_idx: got %0d want %0d", name, err_m, exp_err);
        end
        checks++;
        if (pass_m !== exp_pass) begin
            failures++;
            $display("FAIL %s pass: got %b want %b", name, pass_m, exp_pass);
        end
        checks++;
        if (busy_m !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy_m);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start2 = 1'b0; start0 = 1'b0; sel = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({abcd2, busy2, done2, table2, pass2, mm2, err2} !== 31'd0 ||
            {abcd0, busy0, done0, table0, pass0, mm0, err0} !== 31'd0) begin
            failures++;
            $display("FAIL reset_state: got %h/%h want 0",
                     {abcd2, busy2, done2, table2, pass2, mm2, err2},
                     {abcd0, busy0, done0, table0, pass0, mm0, err0});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_correct;
        int cy, ab, bb, pb;
        run_sweep(1'b0, 0, 0, cy, ab, bb, pb);
        check_result("correct", cy, 48, 16'hFCB1, 5'd0, 4'd0, 1'b1);
        checks++;
        if (ab != 0) begin
            failures++;
            $display("FAIL correct abcd_steps: got %0d bad cycles want 0", ab);
        end
        checks++;
        if (bb != 0 || pb != 0) begin
            failures++;
            $display("FAIL correct busy_pass_during: got %0d/%0d bad want 0/0", bb, pb);
        end
        @(negedge clk);
        checks++;
        if (done2 !== 1'b0 || pass2 !== 1'b1 || abcd2 !== 4'd0) begin
            failures++;
            $display("FAIL correct after_done: got done=%b pass=%b abcd=%0d want 0/1/0", done2, pass2, abcd2);
        end
    endtask

    task automatic test_faults;
        int cy, ab, bb, pb;
        run_sweep(1'b0, 1, 0, cy, ab, bb, pb);
        check_result("stuck0", cy, 48, 16'h0000, 5'd10, 4'd0, 1'b0);
        run_sweep(1'b0, 2, 0, cy, ab, bb, pb);
        check_result("fault9", cy, 48, 16'hFEB1, 5'd1, 4'd9, 1'b0);
        run_sweep(1'b0, 3, 0, cy, ab, bb, pb);
        check_result("inverted", cy, 48, 16'h034E, 5'd16, 4'd0, 1'b0);
    endtask

    task automatic test_reset_mid_sweep;
        int cy, ab, bb, pb;
        int guard;
        sel = 1'b0; mode = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        guard = 0;
        while (abcd2 !== 4'd7 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (abcd2 !== 4'd7) begin
            failures++;
            $display("FAIL midreset reach7: got %0d want 7", abcd2);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({abcd2, busy2, done2, table2, pass2, mm2, err2} !== 31'd0) begin
            failures++;
            $display("FAIL midreset outputs: got %h want 0", {abcd2, busy2, done2, table2, pass2, mm2, err2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(1'b0, 0, 0, cy, ab, bb, pb);
        check_result("after_reset", cy, 48, 16'hFCB1, 5'd0, 4'd0, 1'b1);
    endtask

    task automatic test_start_ignored;
        int cy, ab, bb, pb;
        run_sweep(1'b0, 0, 1, cy, ab, bb, pb);
        check_result("ignored_start", cy, 48, 16'hFCB1, 5'd0, 4'd0, 1'b1);
        checks++;
        if (ab != 0) begin
            failures++;
            $display("FAIL ignored_start abcd_steps: got %0d bad cycles want 0", ab);
        end
    endtask

    task automatic test_settle0;
        int cy, ab, bb, pb;
        run_sweep(1'b1, 0, 0, cy, ab, bb, pb);
        check_result("settle0", cy, 16, 16'hFCB1, 5'd0, 4'd0, 1'b1);
        checks++;
        if (ab != 0) begin
            failures++;
            $display("FAIL settle0 abcd_steps: got %0d bad cycles want 0", ab);
        end
    endtask

    task automatic test_back_to_back;
        int cycles;
        sel = 1'b1; mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        cycles = 0;
        while (done0 !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles != 16) begin
            failures++;
            $display("FAIL b2b first_latency: got %0d want 16", cycles);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL b2b idle_gap: got busy=%b done=%b want 0/0", busy0, done0);
        end
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || abcd0 !== 4'd0 || table0 !== 16'd0) begin
            failures++;
            $display("FAIL b2b restart: got busy=%b abcd=%0d table=%h want 1/0/0000", busy0, abcd0, table0);
        end
        cycles = 0;
        while (done0 !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles != 16 || pass0 !== 1'b1 || table0 !== 16'hFCB1) begin
            failures++;
            $display("FAIL b2b second: got cycles=%0d pass=%b table=%h want 16/1/fcb1", cycles, pass0, table0);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_correct;
        test_faults;
        test_reset_mid_sweep;
        test_start_ignored;
        test_settle0;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
